// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared widths, ALU op codes, memory-stage FSM state codes and small helper
// functions for the memory-access pipeline stage.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_access_pkg;

   localparam int REG_BUS          = 32;
   localparam int REG_ADDR_BUS     = 5;
   localparam int ALU_OP_BUS       = 8;
   localparam int RAM_ADDR_BUS     = 32;
   localparam int MEM_BYTE_CNT_BUS = 3;

   // Execute-stage op codes reused by the memory stage
   localparam logic [ALU_OP_BUS-1:0] EXE_NOP_OP = 8'h00;
   localparam logic [ALU_OP_BUS-1:0] EXE_ADD_OP = 8'h20;
   localparam logic [ALU_OP_BUS-1:0] EXE_LB_OP  = 8'hE0;
   localparam logic [ALU_OP_BUS-1:0] EXE_LH_OP  = 8'hE1;
   localparam logic [ALU_OP_BUS-1:0] EXE_LW_OP  = 8'hE3;
   localparam logic [ALU_OP_BUS-1:0] EXE_LBU_OP = 8'hE4;
   localparam logic [ALU_OP_BUS-1:0] EXE_LHU_OP = 8'hE5;
   localparam logic [ALU_OP_BUS-1:0] EXE_SB_OP  = 8'hE8;
   localparam logic [ALU_OP_BUS-1:0] EXE_SH_OP  = 8'hE9;
   localparam logic [ALU_OP_BUS-1:0] EXE_SW_OP  = 8'hEB;

   typedef enum logic [1:0] {
      MEM_IDLE   = 2'd0,
      MEM_ACCESS = 2'd1,
      MEM_WAIT   = 2'd2,
      MEM_DONE   = 2'd3
   } mem_state_t;

   // Number of byte transfers an op needs
   function automatic logic [MEM_BYTE_CNT_BUS-1:0] byte_count(input logic [ALU_OP_BUS-1:0] aluop);
      case (aluop)
         EXE_LW_OP, EXE_SW_OP:             byte_count = 3'd4;
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: byte_count = 3'd2;
         default:                          byte_count = 3'd1;
      endcase
   endfunction

   function automatic logic is_store(input logic [ALU_OP_BUS-1:0] aluop);
      case (aluop)
         EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_store = 1'b1;
         default:                         is_store = 1'b0;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [ALU_OP_BUS-1:0] aluop,
                                          input logic [1:0]            addr_lo);
      case (aluop)
         EXE_LW_OP, EXE_SW_OP:             is_misaligned = (addr_lo != 2'd0);
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: is_misaligned = addr_lo[0];
         default:                          is_misaligned = 1'b0;
      endcase
   endfunction

   // Little-endian byte lane select
   function automatic logic [7:0] get_lane(input logic [REG_BUS-1:0] data,
                                           input logic [1:0]         idx);
      case (idx)
         2'd0:    get_lane = data[7:0];
         2'd1:    get_lane = data[15:8];
         2'd2:    get_lane = data[23:16];
         2'd3:    get_lane = data[31:24];
         default: get_lane = data[7:0];
      endcase
   endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// -----------------------------------------------------------------------------
// load_ext
// Combinational sign/zero extension of the assembled load buffer by op code.
// Ports:
//   i_aluop  in  ALU_OP_BUS  load op code (LB/LBU/LH/LHU/LW)
//   i_buf    in  REG_BUS     assembled little-endian load buffer
//   o_data   out REG_BUS     extended load result (0 for non-load ops)
// -----------------------------------------------------------------------------
module load_ext
   import mem_access_pkg::*;
(
   input  logic [ALU_OP_BUS-1:0] i_aluop,
   input  logic [REG_BUS-1:0]    i_buf,
   output logic [REG_BUS-1:0]    o_data
);

   // Extension select by load width and signedness
   always_comb begin
      o_data = 32'd0;
      case (i_aluop)
         EXE_LB_OP:  o_data = {{24{i_buf[7]}}, i_buf[7:0]};
         EXE_LBU_OP: o_data = {24'd0, i_buf[7:0]};
         EXE_LH_OP:  o_data = {{16{i_buf[15]}}, i_buf[15:0]};
         EXE_LHU_OP: o_data = {16'd0, i_buf[15:0]};
         EXE_LW_OP:  o_data = i_buf;
         default:    o_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// Memory-access pipeline stage. Performs loads/stores as byte-serial transfers
// on an 8-bit RAM port using a request/grant handshake, stalls the pipeline
// while busy, and returns extended load data or passes ALU results through.
// Optional feature macro: MEM_ALIGN_CHECK_EN (reject misaligned W/H accesses,
// flagging them on misalign_o instead of touching RAM).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wd_i/wreg_i/wdata_i   destination, write enable, ALU result from EX/MEM
//   aluop_i           op code;  mem_rw_i  load/store pending
//   mem_addr_i/mem_wdata_i  effective byte address, store data
//   ram_req_o/ram_gnt_i   byte request / grant
//   ram_addr_o/ram_wr_o/ram_wdata_o/ram_rdata_i  byte address, direction, data
//   wd_o/wreg_o/wdata_o   to MEM/WB
//   stallreq_o        pipeline stall request;  misalign_o  misaligned-access flag
// -----------------------------------------------------------------------------
module mem_access
   import mem_access_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [REG_ADDR_BUS-1:0] wd_i,
   input  logic                    wreg_i,
   input  logic [REG_BUS-1:0]      wdata_i,
   input  logic [ALU_OP_BUS-1:0]   aluop_i,
   input  logic                    mem_rw_i,
   input  logic [RAM_ADDR_BUS-1:0] mem_addr_i,
   input  logic [REG_BUS-1:0]      mem_wdata_i,
   output logic                    ram_req_o,
   input  logic                    ram_gnt_i,
   output logic [RAM_ADDR_BUS-1:0] ram_addr_o,
   output logic                    ram_wr_o,
   output logic [7:0]              ram_wdata_o,
   input  logic [7:0]              ram_rdata_i,
   output logic [REG_ADDR_BUS-1:0] wd_o,
   output logic                    wreg_o,
   output logic [REG_BUS-1:0]      wdata_o,
   output logic                    stallreq_o,
   output logic                    misalign_o
);

   mem_state_t                  r_state;
   logic [MEM_BYTE_CNT_BUS-1:0] r_cnt;
   logic [REG_BUS-1:0]          r_buf;
   logic                        r_rd_pend;
   logic                        r_ram_req;
   logic [RAM_ADDR_BUS-1:0]     r_ram_addr;
   logic                        r_ram_wr;
   logic [7:0]                  r_ram_wdata;
   logic                        r_misalign;

   logic [MEM_BYTE_CNT_BUS-1:0] w_nbytes;
   logic [MEM_BYTE_CNT_BUS-1:0] w_cnt_nxt;
   logic                        w_last;
   logic                        w_store;
   logic                        w_misaligned;
   logic [1:0]                  w_cap_idx;
   logic [REG_BUS-1:0]          w_ext;

   assign w_nbytes  = byte_count(aluop_i);
   assign w_store   = is_store(aluop_i);
   assign w_cnt_nxt = r_cnt + 3'd1;
   assign w_last    = (w_cnt_nxt == w_nbytes);
   // cnt has already advanced past the granted byte when its data arrives
   assign w_cap_idx = r_cnt[1:0] - 2'd1;

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misaligned = is_misaligned(aluop_i, mem_addr_i[1:0]);
`else
   assign w_misaligned = 1'b0;
`endif

   // Transfer FSM with registered RAM-port outputs and misalign flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= MEM_IDLE;
         r_cnt       <= 3'd0;
         r_ram_req   <= 1'b0;
         r_ram_addr  <= 32'd0;
         r_ram_wr    <= 1'b0;
         r_ram_wdata <= 8'd0;
         r_misalign  <= 1'b0;
      end else begin
         case (r_state)
            MEM_IDLE: begin
               r_misalign <= 1'b0;
               if (mem_rw_i) begin
                  r_cnt <= 3'd0;
                  if (w_misaligned) begin
                     r_state    <= MEM_DONE;
                     r_misalign <= 1'b1;
                  end else begin
                     r_state     <= MEM_ACCESS;
                     r_ram_req   <= 1'b1;
                     r_ram_addr  <= mem_addr_i;
                     r_ram_wr    <= w_store;
                     r_ram_wdata <= get_lane(mem_wdata_i, 2'd0);
                  end
               end else begin
                  r_state <= MEM_IDLE;
               end
            end
            MEM_ACCESS: begin
               // Without a grant everything on the RAM port holds
               if (ram_gnt_i) begin
                  r_cnt <= w_cnt_nxt;
                  if (w_last) begin
                     r_ram_req <= 1'b0;
                     r_ram_wr  <= 1'b0;
                     r_state   <= w_store ? MEM_DONE : MEM_WAIT;
                  end else begin
                     r_ram_addr  <= mem_addr_i + {{(RAM_ADDR_BUS-MEM_BYTE_CNT_BUS){1'b0}}, w_cnt_nxt};
                     r_ram_wdata <= get_lane(mem_wdata_i, w_cnt_nxt[1:0]);
                  end
               end else begin
                  r_state <= MEM_ACCESS;
               end
            end
            MEM_WAIT: begin
               r_state <= MEM_DONE;
            end
            MEM_DONE: begin
               r_state    <= MEM_IDLE;
               r_misalign <= 1'b0;
            end
            default: begin
               r_state <= MEM_IDLE;
            end
         endcase
      end
   end

   // Load buffer: cleared at op start, filled one lane the cycle after each read grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf     <= 32'd0;
         r_rd_pend <= 1'b0;
      end else begin
         r_rd_pend <= (r_state == MEM_ACCESS) && ram_gnt_i && !w_store;
         if ((r_state == MEM_IDLE) && mem_rw_i) begin
            r_buf <= 32'd0;
         end else if (r_rd_pend) begin
            r_buf[{w_cap_idx, 3'b000} +: 8] <= ram_rdata_i;
         end else begin
            r_buf <= r_buf;
         end
      end
   end

   load_ext u_load_ext (
      .i_aluop (aluop_i),
      .i_buf   (r_buf),
      .o_data  (w_ext)
   );

   assign ram_req_o   = r_ram_req;
   assign ram_addr_o  = r_ram_addr;
   assign ram_wr_o    = r_ram_wr;
   assign ram_wdata_o = r_ram_wdata;
   assign misalign_o  = r_misalign;

   assign stallreq_o = mem_rw_i && (r_state != MEM_DONE);
   assign wd_o       = wd_i;
   // A rejected misaligned op must not reach the register file
   assign wreg_o     = wreg_i && !stallreq_o && !r_misalign;

   // Result mux: extended load data in DONE, otherwise ALU pass-through
   always_comb begin
      wdata_o = wdata_i;
      if (mem_rw_i && (r_state == MEM_DONE)) begin
         if (w_store) begin
            wdata_o = 32'd0;
         end else begin
            wdata_o = w_ext;
         end
      end else begin
         wdata_o = wdata_i;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
`timescale 1ns/1ps
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic [7:0]  aluop_i;
   logic        mem_rw_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic        ram_req_o;
   logic        ram_gnt_i;
   logic [31:0] ram_addr_o;
   logic        ram_wr_o;
   logic [7:0]  ram_wdata_o;
   logic [7:0]  ram_rdata_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        stallreq_o;
   logic        misalign_o;

   int n_assert = 0;
   int n_fail   = 0;

   // RAM model: read table, plus logs of every granted read/write
   logic [7:0]  rom [0:1023];
   logic [31:0] rd_addr [0:31];
   logic [31:0] wr_addr [0:15];
   logic [7:0]  wr_data [0:15];
   int          rd_n;
   int          wr_n;

   always #5 clk = ~clk;

   mem_access dut (
      .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
      .aluop_i(aluop_i), .mem_rw_i(mem_rw_i), .mem_addr_i(mem_addr_i),
      .mem_wdata_i(mem_wdata_i), .ram_req_o(ram_req_o), .ram_gnt_i(ram_gnt_i),
      .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_wdata_o(ram_wdata_o),
      .ram_rdata_i(ram_rdata_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .stallreq_o(stallreq_o), .misalign_o(misalign_o)
   );

   always @(posedge clk) begin
      if (rst) begin
         rd_n        <= 0;
         wr_n        <= 0;
         ram_rdata_i <= 8'h00;
      end else if (ram_req_o && ram_gnt_i) begin
         if (ram_wr_o) begin
            wr_addr[wr_n[3:0]] <= ram_addr_o;
            wr_data[wr_n[3:0]] <= ram_wdata_o;
            wr_n               <= wr_n + 1;
         end else begin
            rd_addr[rd_n[4:0]] <= ram_addr_o;
            ram_rdata_i        <= rom[ram_addr_o[9:0]];
            rd_n               <= rd_n + 1;
         end
      end
   end

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Present a memory op; called just after a falling edge
   task automatic start_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata);
      aluop_i     = op;
      mem_addr_i  = addr;
      mem_wdata_i = sdata;
      mem_rw_i    = 1'b1;
      wreg_i      = !is_store(op);
      wd_i        = 5'd7;
      wdata_i     = 32'hDEAD_0000;
   endtask

   // Count stalled cycles until DONE, bounded
   task automatic wait_done(input string tag, output int stalls);
      stalls = 0;
      #1;
      while (stallreq_o && stalls < 40) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      n_assert++;
      assert (!stallreq_o) else begin
         n_fail++;
         $error("FAIL %s_timeout observed=stalled expected=done", tag);
      end
   endtask

   task automatic end_op();
      mem_rw_i = 1'b0;
      aluop_i  = EXE_NOP_OP;
      @(negedge clk);
   endtask

   initial begin
      int st;
      int base;
      rst = 1'b1; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'd0; aluop_i = EXE_NOP_OP;
      mem_rw_i = 1'b0; mem_addr_i = 32'd0; mem_wdata_i = 32'd0; ram_gnt_i = 1'b1;
      rom[10'h100] = 8'h78; rom[10'h101] = 8'h56; rom[10'h102] = 8'h34; rom[10'h103] = 8'h12;
      rom[10'h110] = 8'h80;
      rom[10'h120] = 8'h34; rom[10'h121] = 8'h92;

      // Reset state
      repeat (2) @(negedge clk);
      check1 ("rst_req",      ram_req_o,   1'b0);
      check32("rst_addr",     ram_addr_o,  32'd0);
      check1 ("rst_wr",       ram_wr_o,    1'b0);
      check32("rst_wdata",    {24'd0, ram_wdata_o}, 32'd0);
      check1 ("rst_misalign", misalign_o,  1'b0);
      check1 ("rst_stall",    stallreq_o,  1'b0);
      rst = 1'b0;
      @(negedge clk);

      // ALU pass-through, grant asserted but ignored outside ACCESS
      aluop_i = EXE_ADD_OP; wdata_i = 32'h0000_1234; wreg_i = 1'b1; wd_i = 5'd3;
      #1;
      check32("add_wdata", wdata_o, 32'h0000_1234);
      check1 ("add_wreg",  wreg_o,  1'b1);
      check32("add_wd",    {27'd0, wd_o}, 32'd3);
      check1 ("add_stall", stallreq_o, 1'b0);
      check1 ("add_req",   ram_req_o,  1'b0);
      @(negedge clk);
      wdata_i = 32'hCAFE_F00D;
      #1;
      check32("add2_wdata", wdata_o, 32'hCAFE_F00D);
      check1 ("add2_req",   ram_req_o, 1'b0);
      @(negedge clk);

      // LW at 0x100, grant every cycle
      base = rd_n;
      start_op(EXE_LW_OP, 32'h100, 32'd0);
      #1;
      check1("lw_idle_wreg", wreg_o, 1'b0);
      wait_done("lw", st);
      check32("lw_stalls", st, 32'd6);
      check32("lw_data",   wdata_o, 32'h1234_5678);
      check1 ("lw_wreg",   wreg_o, 1'b1);
      check32("lw_nreads", rd_n - base, 32'd4);
      for (int k = 0; k < 4; k++) check32("lw_addr", rd_addr[base + k], 32'h100 + k);
      end_op();

      // LB / LBU of 0x80
      start_op(EXE_LB_OP, 32'h110, 32'd0);
      wait_done("lb", st);
      check32("lb_stalls", st, 32'd3);
      check32("lb_data",   wdata_o, 32'hFFFF_FF80);
      end_op();
      start_op(EXE_LBU_OP, 32'h110, 32'd0);
      wait_done("lbu", st);
      check32("lbu_data", wdata_o, 32'h0000_0080);
      end_op();

      // LH / LHU of 0x9234
      start_op(EXE_LH_OP, 32'h120, 32'd0);
      wait_done("lh", st);
      check32("lh_stalls", st, 32'd4);
      check32("lh_data",   wdata_o, 32'hFFFF_9234);
      end_op();
      start_op(EXE_LHU_OP, 32'h120, 32'd0);
      wait_done("lhu", st);
      check32("lhu_data", wdata_o, 32'h0000_9234);
      end_op();

      // SB: one write, 3 cycles total
      base = wr_n;
      start_op(EXE_SB_OP, 32'h300, 32'h1122_33A5);
      wait_done("sb", st);
      check32("sb_stalls", st, 32'd2);
      check32("sb_wdata",  wdata_o, 32'd0);
      check32("sb_waddr",  wr_addr[base], 32'h300);
      check32("sb_wbyte",  {24'd0, wr_data[base]}, 32'h0000_00A5);
      end_op();

      // SH 0xBEEF at 0x202, grant low on alternate cycles
      base = wr_n;
      ram_gnt_i = 1'b0;
      start_op(EXE_SH_OP, 32'h202, 32'h0000_BEEF);
      @(negedge clk);
      check1 ("sh_req0",    ram_req_o, 1'b1);
      check1 ("sh_wr0",     ram_wr_o,  1'b1);
      check32("sh_addr0",   ram_addr_o, 32'h202);
      check32("sh_byte0",   {24'd0, ram_wdata_o}, 32'h0000_00EF);
      @(negedge clk);
      check32("sh_addr0_hold", ram_addr_o, 32'h202);
      check32("sh_byte0_hold", {24'd0, ram_wdata_o}, 32'h0000_00EF);
      ram_gnt_i = 1'b1;
      @(negedge clk);
      check32("sh_addr1",   ram_addr_o, 32'h203);
      check32("sh_byte1",   {24'd0, ram_wdata_o}, 32'h0000_00BE);
      ram_gnt_i = 1'b0;
      @(negedge clk);
      check32("sh_addr1_hold", ram_addr_o, 32'h203);
      check1 ("sh_stall_mid",  stallreq_o, 1'b1);
      ram_gnt_i = 1'b1;
      @(negedge clk);
      #1;
      check1 ("sh_done_stall", stallreq_o, 1'b0);
      check1 ("sh_done_req",   ram_req_o,  1'b0);
      check32("sh_done_wdata", wdata_o, 32'd0);
      check1 ("sh_done_wreg",  wreg_o, 1'b0);
      check32("sh_nwrites",    wr_n - base, 32'd2);
      check32("sh_w0",         {wr_addr[base][23:0], wr_data[base]}, 32'h0002_02EF);
      check32("sh_w1",         {wr_addr[base + 1][23:0], wr_data[base + 1]}, 32'h0002_03BE);
      end_op();

      // Reset during the 3rd byte of an LW
      start_op(EXE_LW_OP, 32'h100, 32'd0);
      repeat (3) @(negedge clk);
      check32("rstmid_addr_pre", ram_addr_o, 32'h102);
      rst = 1'b1;
      #1;
      check1 ("rstmid_req",   ram_req_o,  1'b0);
      check32("rstmid_addr",  ram_addr_o, 32'd0);
      check1 ("rstmid_stall", stallreq_o, 1'b1);
      mem_rw_i = 1'b0; aluop_i = EXE_ADD_OP; wdata_i = 32'h0BAD_F00D;
      #1;
      check1 ("rstmid_stall_off", stallreq_o, 1'b0);
      check32("rstmid_pass",      wdata_o, 32'h0BAD_F00D);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check1("rstmid_req_after", ram_req_o, 1'b0);

      // Misaligned LW at 0x101
      rom[10'h101] = 8'h11; rom[10'h102] = 8'h22; rom[10'h103] = 8'h33; rom[10'h104] = 8'h44;
      base = rd_n;
      start_op(EXE_LW_OP, 32'h101, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
      @(negedge clk);
      #1;
      check1 ("mis_flag",   misalign_o, 1'b1);
      check1 ("mis_req",    ram_req_o,  1'b0);
      check1 ("mis_stall",  stallreq_o, 1'b0);
      check1 ("mis_wreg",   wreg_o,     1'b0);
      end_op();
      check1 ("mis_flag_clr", misalign_o, 1'b0);
      check32("mis_nreads",   rd_n - base, 32'd0);
`else
      wait_done("mis", st);
      check32("mis_stalls", st, 32'd6);
      check32("mis_data",   wdata_o, 32'h4433_2211);
      check1 ("mis_flag",   misalign_o, 1'b0);
      check32("mis_nreads", rd_n - base, 32'd4);
      for (int k = 0; k < 4; k++) check32("mis_addr", rd_addr[base + k], 32'h101 + k);
      end_op();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
